// File: rtl/writeback_queue_if.sv
// Register-file write-back bundle: request side from execute/memory, drain side to the register file,
// plus hazard/status outputs for decode.
interface writeback_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              WB_VALID_SE;
    logic              WB_READY_SW;
    logic [ADDR_W-1:0] WB_ADR_SE;
    logic [DATA_W-1:0] WB_DATA_SE;
    logic              WB_HOLD_SE;
    logic              FLUSH_SE;
    logic [DATA_W-1:0] WDATA_SW;
    logic [ADDR_W-1:0] WADR_SW;
    logic              WENABLE_SW;
    logic [DATA_W-1:0] WRITE_PC_SD;
    logic              WRITE_PC_ENABLE_SD;
    logic [32:0]       PENDING_SW;
    logic [CNT_W-1:0]  COUNT_SW;
    logic              ILLEGAL_SW;

    modport slave (
        input  WB_VALID_SE, WB_ADR_SE, WB_DATA_SE, WB_HOLD_SE, FLUSH_SE,
        output WB_READY_SW, WDATA_SW, WADR_SW, WENABLE_SW, WRITE_PC_SD,
               WRITE_PC_ENABLE_SD, PENDING_SW, COUNT_SW, ILLEGAL_SW
    );

    modport master (
        output WB_VALID_SE, WB_ADR_SE, WB_DATA_SE, WB_HOLD_SE, FLUSH_SE,
        input  WB_READY_SW, WDATA_SW, WADR_SW, WENABLE_SW, WRITE_PC_SD,
               WRITE_PC_ENABLE_SD, PENDING_SW, COUNT_SW, ILLEGAL_SW
    );
endinterface

// File: rtl/writeback_queue.sv
// In-order write-back FIFO draining one entry per cycle onto the GPR or PC write port,
// with a pending-write mask over queued and staged writes for decode hazard checks.
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    writeback_queue_if.slave  wb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(32);

    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] wadr_q, wadr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              pc_en_q, pc_en_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              illegal_q, illegal_d;

    logic              ready;
    logic              accept;
    logic              addr_zero;
    logic              addr_illegal;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    // Ready deliberately ignores a same-edge pop so it has no path from the hold input.
    assign ready        = (count_q < CNT_W'(DEPTH)) && !wb.FLUSH_SE;
    assign accept       = wb.WB_VALID_SE && ready;
    assign addr_zero    = (wb.WB_ADR_SE == '0);
    assign addr_illegal = (wb.WB_ADR_SE > PC_ADDR);
    assign push         = accept && !addr_zero && !addr_illegal;
    assign pop          = !wb.FLUSH_SE && !wb.WB_HOLD_SE && (count_q != '0);
    assign head_addr    = fifo_addr_q[head_q];
    assign head_data    = fifo_data_q[head_q];

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        wen_d     = 1'b0;
        wadr_d    = wadr_q;
        wdata_d   = wdata_q;
        pc_en_d   = 1'b0;
        pc_d      = pc_q;
        illegal_d = illegal_q || (accept && addr_illegal);

        if (wb.FLUSH_SE) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            wadr_d  = '0;
            wdata_d = '0;
            pc_d    = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
                if (head_addr == PC_ADDR) begin
                    pc_en_d = 1'b1;
                    pc_d    = head_data;
                end else begin
                    wen_d   = 1'b1;
                    wadr_d  = head_addr;
                    wdata_d = head_data;
                end
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wen_q     <= 1'b0;
            wadr_q    <= '0;
            wdata_q   <= '0;
            pc_en_q   <= 1'b0;
            pc_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wen_q     <= wen_d;
            wadr_q    <= wadr_d;
            wdata_q   <= wdata_d;
            pc_en_q   <= pc_en_d;
            pc_q      <= pc_d;
            illegal_q <= illegal_d;
        end
    end

    // Storage needs no reset: occupancy is tracked solely by head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[tail_q] <= wb.WB_ADR_SE;
            fifo_data_q[tail_q] <= wb.WB_DATA_SE;
        end
    end

    logic [32:0] entry_mask [DEPTH];
    logic [32:0] stage_mask;
    logic [32:0] pending;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [PTR_W-1:0] offset;
        logic             valid;
        logic [32:0]      mask;

        assign offset = PTR_W'(gi) - head_q;
        assign valid  = ({1'b0, offset} < count_q);

        always_comb begin
            mask = '0;
            for (int b = 0; b < 33; b++) begin
                mask[b] = valid && (fifo_addr_q[gi] == ADDR_W'(b));
            end
        end

        assign entry_mask[gi] = mask;
    end

    always_comb begin
        stage_mask = '0;
        for (int b = 0; b < 32; b++) begin
            stage_mask[b] = wen_q && (wadr_q == ADDR_W'(b));
        end
        stage_mask[32] = pc_en_q;
    end

    always_comb begin
        pending = stage_mask;
        for (int i = 0; i < DEPTH; i++) begin
            pending = pending | entry_mask[i];
        end
    end

    assign wb.WB_READY_SW        = ready;
    assign wb.WENABLE_SW         = wen_q;
    assign wb.WADR_SW            = wadr_q;
    assign wb.WDATA_SW           = wdata_q;
    assign wb.WRITE_PC_ENABLE_SD = pc_en_q;
    assign wb.WRITE_PC_SD        = pc_q;
    assign wb.PENDING_SW         = pending;
    assign wb.COUNT_SW           = count_q;
    assign wb.ILLEGAL_SW         = illegal_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed table of per-cycle requests with hand-computed outputs, followed by
// hand-written async-reset and latency sequences.
module tb_writeback_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int NV     = 29;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    writeback_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb_if ();

    writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb_if.slave)
    );

    typedef struct {
        logic        v;
        logic [5:0]  a;
        logic [31:0] d;
        logic        h;
        logic        f;
        logic        e_wen;
        logic [5:0]  e_wadr;
        logic [31:0] e_wdata;
        logic        e_pcen;
        logic [31:0] e_pc;
        logic [32:0] e_pend;
        logic [2:0]  e_cnt;
        logic        e_rdy;
        logic        e_ill;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t mk(input logic v, input logic [5:0] a, input logic [31:0] d,
                                input logic h, input logic f,
                                input logic wen, input logic [5:0] wadr, input logic [31:0] wdata,
                                input logic pcen, input logic [31:0] pc, input logic [32:0] pend,
                                input logic [2:0] cnt, input logic rdy, input logic ill);
        vec_t r;
        r.v = v; r.a = a; r.d = d; r.h = h; r.f = f;
        r.e_wen = wen; r.e_wadr = wadr; r.e_wdata = wdata; r.e_pcen = pcen; r.e_pc = pc;
        r.e_pend = pend; r.e_cnt = cnt; r.e_rdy = rdy; r.e_ill = ill;
        return r;
    endfunction

    function automatic logic [32:0] bit33(input int n);
        logic [32:0] one;
        one = 33'd1;
        return one << n;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] a, input logic [31:0] d,
                         input logic h, input logic f);
        wb_if.WB_VALID_SE = v;
        wb_if.WB_ADR_SE   = a;
        wb_if.WB_DATA_SE  = d;
        wb_if.WB_HOLD_SE  = h;
        wb_if.FLUSH_SE    = f;
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, ".wen"},   64'(wb_if.WENABLE_SW),         64'(e.e_wen));
        chk({tag, ".wadr"},  64'(wb_if.WADR_SW),            64'(e.e_wadr));
        chk({tag, ".wdata"}, 64'(wb_if.WDATA_SW),           64'(e.e_wdata));
        chk({tag, ".pcen"},  64'(wb_if.WRITE_PC_ENABLE_SD), 64'(e.e_pcen));
        chk({tag, ".pc"},    64'(wb_if.WRITE_PC_SD),        64'(e.e_pc));
        chk({tag, ".pend"},  64'(wb_if.PENDING_SW),         64'(e.e_pend));
        chk({tag, ".cnt"},   64'(wb_if.COUNT_SW),           64'(e.e_cnt));
        chk({tag, ".rdy"},   64'(wb_if.WB_READY_SW),        64'(e.e_rdy));
        chk({tag, ".ill"},   64'(wb_if.ILLEGAL_SW),         64'(e.e_ill));
    endtask

    initial begin
        vec_t z;
        // In-order drain, last write to r5 wins
        tbl[0]  = mk(1, 5,  32'hA5A5A5A5, 0, 0,  0, 5'd0, 32'h0,        0, 32'h0, bit33(5),             1, 1, 0);
        tbl[1]  = mk(1, 7,  32'h1,        0, 0,  1, 6'd5, 32'hA5A5A5A5, 0, 32'h0, bit33(5) | bit33(7),  1, 1, 0);
        tbl[2]  = mk(1, 5,  32'h2,        0, 0,  1, 6'd7, 32'h1,        0, 32'h0, bit33(5) | bit33(7),  1, 1, 0);
        tbl[3]  = mk(0, 0,  32'h0,        0, 0,  1, 6'd5, 32'h2,        0, 32'h0, bit33(5),             0, 1, 0);
        tbl[4]  = mk(0, 0,  32'h0,        0, 0,  0, 6'd5, 32'h2,        0, 32'h0, 33'h0,                0, 1, 0);
        // Address 0 is swallowed
        tbl[5]  = mk(1, 0,  32'hFFFFFFFF, 0, 0,  0, 6'd5, 32'h2,        0, 32'h0, 33'h0,                0, 1, 0);
        tbl[6]  = mk(0, 0,  32'h0,        0, 0,  0, 6'd5, 32'h2,        0, 32'h0, 33'h0,                0, 1, 0);
        // PC write
        tbl[7]  = mk(1, 32, 32'h80000100, 0, 0,  0, 6'd5, 32'h2,        0, 32'h0,        bit33(32),     1, 1, 0);
        tbl[8]  = mk(0, 0,  32'h0,        0, 0,  0, 6'd5, 32'h2,        1, 32'h80000100, bit33(32),     0, 1, 0);
        tbl[9]  = mk(0, 0,  32'h0,        0, 0,  0, 6'd5, 32'h2,        0, 32'h80000100, 33'h0,         0, 1, 0);
        // Fill under hold, fifth request stalls until after the first pop
        tbl[10] = mk(1, 1,  32'h11, 1, 0,  0, 6'd5, 32'h2,  0, 32'h80000100, bit33(1),                                  1, 1, 0);
        tbl[11] = mk(1, 2,  32'h22, 1, 0,  0, 6'd5, 32'h2,  0, 32'h80000100, bit33(1) | bit33(2),                       2, 1, 0);
        tbl[12] = mk(1, 3,  32'h33, 1, 0,  0, 6'd5, 32'h2,  0, 32'h80000100, bit33(1) | bit33(2) | bit33(3),            3, 1, 0);
        tbl[13] = mk(1, 4,  32'h44, 1, 0,  0, 6'd5, 32'h2,  0, 32'h80000100, bit33(1) | bit33(2) | bit33(3) | bit33(4), 4, 0, 0);
        tbl[14] = mk(1, 6,  32'h66, 1, 0,  0, 6'd5, 32'h2,  0, 32'h80000100, bit33(1) | bit33(2) | bit33(3) | bit33(4), 4, 0, 0);
        tbl[15] = mk(1, 6,  32'h66, 0, 0,  1, 6'd1, 32'h11, 0, 32'h80000100, bit33(1) | bit33(2) | bit33(3) | bit33(4), 3, 1, 0);
        tbl[16] = mk(1, 6,  32'h66, 0, 0,  1, 6'd2, 32'h22, 0, 32'h80000100, bit33(2) | bit33(3) | bit33(4) | bit33(6), 3, 1, 0);
        tbl[17] = mk(0, 0,  32'h0,  0, 0,  1, 6'd3, 32'h33, 0, 32'h80000100, bit33(3) | bit33(4) | bit33(6),            2, 1, 0);
        tbl[18] = mk(0, 0,  32'h0,  0, 0,  1, 6'd4, 32'h44, 0, 32'h80000100, bit33(4) | bit33(6),                       1, 1, 0);
        tbl[19] = mk(0, 0,  32'h0,  0, 0,  1, 6'd6, 32'h66, 0, 32'h80000100, bit33(6),                                  0, 1, 0);
        tbl[20] = mk(0, 0,  32'h0,  0, 0,  0, 6'd6, 32'h66, 0, 32'h80000100, 33'h0,                                     0, 1, 0);
        // Flush (with hold and a valid request) empties everything and takes nothing
        tbl[21] = mk(1, 8,  32'h8,  1, 0,  0, 6'd6, 32'h66, 0, 32'h80000100, bit33(8),                       1, 1, 0);
        tbl[22] = mk(1, 9,  32'h9,  1, 0,  0, 6'd6, 32'h66, 0, 32'h80000100, bit33(8) | bit33(9),            2, 1, 0);
        tbl[23] = mk(1, 10, 32'hA,  1, 0,  0, 6'd6, 32'h66, 0, 32'h80000100, bit33(8) | bit33(9) | bit33(10), 3, 1, 0);
        tbl[24] = mk(1, 11, 32'hB,  1, 1,  0, 6'd0, 32'h0,  0, 32'h0,        33'h0,                          0, 0, 0);
        tbl[25] = mk(0, 0,  32'h0,  0, 0,  0, 6'd0, 32'h0,  0, 32'h0,        33'h0,                          0, 1, 0);
        // Illegal address is sticky, queue keeps working
        tbl[26] = mk(1, 40, 32'h3,  0, 0,  0, 6'd0,  32'h0, 0, 32'h0, 33'h0,                 0, 1, 1);
        tbl[27] = mk(1, 12, 32'hC,  0, 0,  0, 6'd0,  32'h0, 0, 32'h0, bit33(12),             1, 1, 1);
        tbl[28] = mk(1, 13, 32'hD,  0, 0,  1, 6'd12, 32'hC, 0, 32'h0, bit33(12) | bit33(13), 1, 1, 1);

        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        z = mk(0, 0, 0, 0, 0, 0, 6'd0, 32'h0, 0, 32'h0, 33'h0, 0, 1, 0);
        chk_all("reset", z);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].h, tbl[i].f);
            @(posedge clk);
            #1;
            $display("row %0d: v=%0d a=%0d h=%0d f=%0d -> wen=%0d wadr=%0d pcen=%0d cnt=%0d pend=%0h",
                     i, tbl[i].v, tbl[i].a, tbl[i].h, tbl[i].f, wb_if.WENABLE_SW, wb_if.WADR_SW,
                     wb_if.WRITE_PC_ENABLE_SD, wb_if.COUNT_SW, wb_if.PENDING_SW);
            chk_all($sformatf("row%0d", i), tbl[i]);
        end

        // Async reset mid-drain: strobe is high and r13 is queued here
        drive(0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        $display("async reset asserted mid-cycle");
        chk_all("async_rst", z);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Latency: accepted at edge k, strobe visible after edge k+1
        drive(1, 31, 32'h1F, 0, 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0);
        $display("latency: edge k cnt=%0d wen=%0d", wb_if.COUNT_SW, wb_if.WENABLE_SW);
        chk("lat_k.wen",  64'(wb_if.WENABLE_SW), 64'd0);
        chk("lat_k.cnt",  64'(wb_if.COUNT_SW),   64'd1);
        chk("lat_k.pend", 64'(wb_if.PENDING_SW), 64'(bit33(31)));
        @(posedge clk);
        #1;
        $display("latency: edge k+1 wen=%0d wadr=%0d", wb_if.WENABLE_SW, wb_if.WADR_SW);
        chk("lat_k1.wen",   64'(wb_if.WENABLE_SW), 64'd1);
        chk("lat_k1.wadr",  64'(wb_if.WADR_SW),    64'd31);
        chk("lat_k1.wdata", 64'(wb_if.WDATA_SW),   64'h1F);
        chk("lat_k1.pend",  64'(wb_if.PENDING_SW), 64'(bit33(31)));
        @(posedge clk);
        #1;
        chk("lat_k2.wen",  64'(wb_if.WENABLE_SW), 64'd0);
        chk("lat_k2.pend", 64'(wb_if.PENDING_SW), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
